// File: rtl/idli_pkg.sv
// Shared SQI definitions for the idli memory path.
package idli_pkg;

    // One SQI transfer unit: four data lines, one nibble per clock.
    typedef logic [3:0] sqi_data_t;

    // Read-return buffer FSM states.
    typedef enum logic [1:0] {
        RDB_IDLE,
        RDB_FILL,
        RDB_DRAIN
    } rdb_state_t;

    // Nibbles carried by a byte access.
    localparam int SQI_BYTE_NIBBLES = 2;

endpackage

// File: rtl/idli_rdbuf_m.sv
// Read-return buffer: captures nibbles from memory MSB-first and replays
// them to the core LSB-first over valid/ready. Byte reads are extended to a
// full word of DEPTH nibbles.
// Optional build macro IDLI_RDB_ZEXT_EN adds i_rdb_zext, which selects zero
// extension instead of sign extension for byte reads.
module idli_rdbuf_m
    import idli_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter bit RESET = 1'b0
) (
    input  logic      i_rdb_gck,
    input  logic      i_rdb_rst_n,
    input  logic      i_rdb_start,
    input  logic      i_rdb_byte,
`ifdef IDLI_RDB_ZEXT_EN
    input  logic      i_rdb_zext,
`endif
    input  logic      i_rdb_sqi_vld,
    input  sqi_data_t i_rdb_sqi_data,
    output sqi_data_t o_rdb_data,
    output logic      o_rdb_vld,
    input  logic      i_rdb_rdy,
    output logic      o_rdb_busy,
    output logic      o_rdb_done
);

    localparam int CW = $clog2(DEPTH);
    typedef logic [CW-1:0] cnt_t;

    localparam cnt_t WORD_LAST = cnt_t'(DEPTH - 1);
    localparam cnt_t BYTE_LAST = cnt_t'(SQI_BYTE_NIBBLES - 1);

    rdb_state_t state;
    logic       byte_q;
    logic       ext_zero_q;
    cnt_t       cnt;
    cnt_t       idx;
    sqi_data_t  slot [DEPTH];

    logic       zext_in;
    cnt_t       fill_last;
    logic       fill_wr;
    logic       accept;
    logic       ext_sel;
    sqi_data_t  ext_nib;
    sqi_data_t  drain_nib;

`ifdef IDLI_RDB_ZEXT_EN
    assign zext_in = i_rdb_zext;
`else
    assign zext_in = 1'b0;
`endif

    // Datapath decode: write slot, drain nibble select and extension nibble.
    always_comb begin
        fill_last = byte_q ? BYTE_LAST : WORD_LAST;
        fill_wr   = (state == RDB_FILL) && i_rdb_sqi_vld;
        accept    = (state == RDB_DRAIN) && i_rdb_rdy;
        // Past the two captured nibbles of a byte read, replay the extension.
        ext_sel   = byte_q && (int'(idx) >= SQI_BYTE_NIBBLES);
        ext_nib   = ext_zero_q ? '0 : {4{slot[1][3]}};
        drain_nib = ext_sel ? ext_nib : slot[idx];
    end

    // Outputs are pure decodes of the state register plus the handshake.
    always_comb begin
        o_rdb_vld  = (state == RDB_DRAIN);
        o_rdb_busy = (state != RDB_IDLE);
        o_rdb_data = o_rdb_vld ? drain_nib : '0;
        o_rdb_done = accept && (idx == WORD_LAST);
    end

    // Transfer FSM: latch the access type, count captured and replayed nibbles.
    always_ff @(posedge i_rdb_gck) begin
        if (!i_rdb_rst_n) begin
            state      <= RDB_IDLE;
            byte_q     <= 1'b0;
            ext_zero_q <= 1'b0;
            cnt        <= '0;
            idx        <= '0;
        end else begin
            case (state)
                RDB_IDLE: begin
                    if (i_rdb_start) begin
                        byte_q     <= i_rdb_byte;
                        ext_zero_q <= i_rdb_byte & zext_in;
                        cnt        <= '0;
                        state      <= RDB_FILL;
                    end
                end
                RDB_FILL: begin
                    if (i_rdb_sqi_vld) begin
                        // Leave at the terminal count rather than incrementing past it.
                        if (cnt == fill_last) begin
                            idx   <= '0;
                            state <= RDB_DRAIN;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                RDB_DRAIN: begin
                    if (i_rdb_rdy) begin
                        if (idx == WORD_LAST) begin
                            state <= RDB_IDLE;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                default: state <= RDB_IDLE;
            endcase
        end
    end

    // Nibble storage: MSB-first arrival lands in descending slots so slot 0 is the LSB.
    always_ff @(posedge i_rdb_gck) begin
        if (!i_rdb_rst_n) begin
            if (RESET) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    slot[i] <= '0;
                end
            end
        end else if (fill_wr) begin
            slot[fill_last - cnt] <= i_rdb_sqi_data;
        end
    end

`ifndef SYNTHESIS
    // Memory must not present data once the buffer is replaying.
    a_no_sqi_in_drain: assert property (
        @(posedge i_rdb_gck) disable iff (!i_rdb_rst_n)
        (state == RDB_DRAIN) |-> !i_rdb_sqi_vld
    );
`endif

endmodule

// File: doc/idli_rdbuf_m.md
Name: idli_rdbuf_m

Overview:
- Read-return buffer for the SQI memory path: the complement of the write-side nibble reversal.
- Memory returns a value MSB nibble first; the serial core consumes LSB nibble first.
- Block captures the returned nibbles, then replays them to the core in reversed order over a valid/ready handshake.
- Byte reads are sign-extended to a full word.
- Sits between the SQI pin interface and the core's load datapath.

Parameters:
- DEPTH, 4, nibbles per full word; must be >= 2.
- RESET, 0, when 1 the nibble storage is cleared on reset; when 0 storage is not reset.

Ports:
- i_rdb_gck  input  1  clock.
- i_rdb_rst_n  input  1  reset; synchronous, active-low.
- i_rdb_start  input  1  begin a read transfer; honoured only in IDLE.
- i_rdb_byte  input  1  sampled with start; 1 = byte read (2 nibbles), 0 = word read (DEPTH nibbles).
- i_rdb_sqi_vld  input  1  nibble present from memory this cycle.
- i_rdb_sqi_data  input  sqi_data_t  nibble from memory, MSB-first order.
- o_rdb_data  output  sqi_data_t  nibble to core, LSB-first order.
- o_rdb_vld  output  1  o_rdb_data is valid.
- i_rdb_rdy  input  1  core accepts o_rdb_data this cycle.
- o_rdb_busy  output  1  a transfer is in progress (FILL or DRAIN).
- o_rdb_done  output  1  single-cycle pulse on acceptance of the final nibble.

Behaviour:
- Reset: state=IDLE, counters=0, o_rdb_vld=0, o_rdb_busy=0, o_rdb_done=0, o_rdb_data='0. Storage cleared only if RESET=1.
- Reset is synchronous: asserting it mid-FILL or mid-DRAIN aborts the transfer. The block is IDLE on the next edge; no done pulse is generated.
- Effective length N = 2 if the byte flag is set, else DEPTH.
- IDLE:
  - start=1 latches the byte flag, clears cnt, moves to FILL.
  - o_rdb_busy goes high the following cycle.
  - SQI inputs are ignored in IDLE.
- FILL:
  - Each cycle with sqi_vld=1, store the nibble at slot N-1-cnt and increment cnt.
  - On the cycle the N-th nibble is stored, move to DRAIN with idx=0.
  - sqi_vld=0 cycles are stalls with no state change.
- DRAIN:
  - o_rdb_vld=1.
  - o_rdb_data = slot[idx] if idx < N; otherwise an extension nibble of four copies of bit 3 of slot[1] (byte reads only).
  - On vld&&rdy, idx increments.
  - When idx==DEPTH-1 and the nibble is accepted: o_rdb_done pulses that same cycle, and the next state is IDLE.
  - Every read returns exactly DEPTH nibbles to the core.
- Data is held stable while vld=1 and rdy=0.
- o_rdb_data is '0 whenever o_rdb_vld=0.
- Latency: the first output nibble is valid the cycle after the last memory nibble is captured. No same-cycle bypass.
- start while busy is ignored, including on the done cycle. Back-to-back transfers require start on a cycle where state=IDLE.
- Counter widths: $clog2(DEPTH) bits. cnt and idx never wrap, because the transitions occur at terminal counts.
- sqi_vld in DRAIN is ignored; it is a memory-side protocol error, covered by an assertion.

Optional Feature:
- Macro: IDLI_RDB_ZEXT_EN.
- When defined:
  - Extra input port i_rdb_zext (1 bit), sampled with start.
  - If set on a byte read, the extension nibbles are 4'h0 instead of sign copies.
  - It has no effect on word reads.
- When undefined: the port is absent and byte reads are always sign-extended.

Decomposition:
- Shared package idli_pkg:
  - Existing sqi_data_t.
  - New enum rdb_state_t {RDB_IDLE, RDB_FILL, RDB_DRAIN}.
  - Constant SQI_BYTE_NIBBLES = 2.
- No sub-module. Storage, counters and FSM are implemented inline in a single module.

Test Plan:
- Word read: start, byte=0; memory sends A,B,C,D on consecutive cycles; rdy=1 -> output D,C,B,A on consecutive cycles starting the cycle after D is captured; done pulses with A.
- Signed byte: byte=1; memory sends 8,5 -> output 5,8,F,F; done on the final F.
- Positive byte: byte=1; memory sends 3,C -> output C,3,0,0. With IDLI_RDB_ZEXT_EN and zext=1, memory sends 8,5 -> output 5,8,0,0.
- Stalls on both sides:
  - sqi_vld drops for 3 cycles mid-FILL -> no spurious capture.
  - rdy low for 2 cycles after the second output nibble -> o_rdb_data held; order D,C,B,A preserved.
- Start during busy is ignored: the in-flight result is unchanged.
- Reset asserted mid-FILL after 2 nibbles -> next cycle busy=0, vld=0; a fresh word read then returns the correct data.
